// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
// Shift-add multiply (32 cycles) and restoring divide (32 cycles + sign fix-up).
module md_unit #(
    parameter bit MULT_FAST = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    output logic [31:0] HiLoData,
    output logic        Stall,
    output logic        Busy
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] hi;
    logic [31:0] lo;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] rs_raw;

    logic [5:0]  funct;
    logic        special;
    logic        op_mfhi, op_mthi, op_mflo, op_mtlo;
    logic        op_mult, op_multu, op_div, op_divu;
    logic        op_mul, op_dv, op_hilo;
    logic        unused_ins;

    assign funct      = Ins[5:0];
    assign special    = (Ins[31:26] == OP_SPECIAL);
    assign unused_ins = ^Ins[25:6];

    assign op_mfhi  = special && (funct == FN_MFHI);
    assign op_mthi  = special && (funct == FN_MTHI);
    assign op_mflo  = special && (funct == FN_MFLO);
    assign op_mtlo  = special && (funct == FN_MTLO);
    assign op_mult  = special && (funct == FN_MULT);
    assign op_multu = special && (funct == FN_MULTU);
    assign op_div   = special && (funct == FN_DIV);
    assign op_divu  = special && (funct == FN_DIVU);
    assign op_mul   = op_mult | op_multu;
    assign op_dv    = op_div | op_divu;
    assign op_hilo  = op_mfhi | op_mthi | op_mflo | op_mtlo | op_mul | op_dv;

    assign Busy  = (state != S_IDLE);
    assign Stall = Busy & op_hilo;

    always_comb begin
        HiLoData = 32'd0;
        if (!Busy) begin
            if (op_mfhi) begin
                HiLoData = hi;
            end else if (op_mflo) begin
                HiLoData = lo;
            end
        end
    end

    // Operand magnitudes and signs, only meaningful at the issue edge
    logic        signed_op;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;

    assign signed_op = op_mult | op_div;
    assign rs_neg    = signed_op & Rdata1[31];
    assign rt_neg    = signed_op & Rdata2[31];
    assign rs_mag    = rs_neg ? (~Rdata1 + 32'd1) : Rdata1;
    assign rt_mag    = rt_neg ? (~Rdata2 + 32'd1) : Rdata2;

    logic [63:0] fast_a;
    logic [63:0] fast_b;
    logic [63:0] fast_prod;

    assign fast_a    = {{32{rs_neg}}, Rdata1};
    assign fast_b    = {{32{rt_neg}}, Rdata2};
    assign fast_prod = fast_a * fast_b;

    logic [63:0] mul_sum;
    logic [63:0] mul_res;

    assign mul_sum = acc + (mplier[0] ? mcand : 64'd0);
    assign mul_res = neg_res ? (~mul_sum + 64'd1) : mul_sum;

    // acc holds {remainder, dividend/quotient shift register} while dividing
    logic [32:0] div_part;
    logic [32:0] div_trial;
    logic [63:0] div_next;

    assign div_part  = {acc[63:32], acc[31]};
    assign div_trial = div_part - {1'b0, mcand[31:0]};
    assign div_next  = div_trial[32] ? {div_part[31:0], acc[30:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (op_mul) begin
                    state_nx = MULT_FAST ? S_IDLE : S_MUL;
                end else if (op_dv) begin
                    state_nx = S_DIV;
                end
            end
            S_MUL: begin
                if (count == 6'd1) begin
                    state_nx = S_IDLE;
                end
            end
            S_DIV: begin
                if (count == 6'd1) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            count    <= 6'd0;
            acc      <= 64'd0;
            mcand    <= 64'd0;
            mplier   <= 32'd0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            rs_raw   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_mthi) begin
                        hi <= Rdata1;
                    end
                    if (op_mtlo) begin
                        lo <= Rdata1;
                    end
                    if (op_mul && MULT_FAST) begin
                        hi <= fast_prod[63:32];
                        lo <= fast_prod[31:0];
                    end else if (op_mul || op_dv) begin
                        count    <= 6'd32;
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        div_zero <= (Rdata2 == 32'd0);
                        rs_raw   <= Rdata1;
                        if (op_mul) begin
                            acc    <= 64'd0;
                            mcand  <= {32'd0, rs_mag};
                            mplier <= rt_mag;
                        end else begin
                            acc    <= {32'd0, rs_mag};
                            mcand  <= {32'd0, rt_mag};
                            mplier <= 32'd0;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= {mcand[62:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    count  <= count - 6'd1;
                    if (count == 6'd1) begin
                        hi <= mul_res[63:32];
                        lo <= mul_res[31:0];
                    end
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count - 6'd1;
                end
                S_FIX: begin
                    // Divide by zero reports the dividend as issued, not its magnitude
                    if (div_zero) begin
                        hi <= rs_raw;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
                        lo <= neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Ins = 32'd0;
    logic [31:0] Rdata1 = 32'd0;
    logic [31:0] Rdata2 = 32'd0;
    logic [31:0] HiLoData;
    logic        Stall;
    logic        Busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] mon_e;
    logic [5:0]  r_fn;
    logic [31:0] r_a;
    logic [31:0] r_b;

    md_unit #(.MULT_FAST(1'b0)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Ins      (Ins),
        .Rdata1   (Rdata1),
        .Rdata2   (Rdata2),
        .HiLoData (HiLoData),
        .Stall    (Stall),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_hilo(input logic [5:0] fn);
        return fn inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    task automatic model_apply(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            F_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_DIV, F_DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (fn == F_DIV) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            F_MTHI: m_hi = a;
            F_MTLO: m_lo = a;
            default: begin
            end
        endcase
    endtask

    task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        Ins    = {6'h00, 20'($urandom), fn};
        Rdata1 = a;
        Rdata2 = b;
    endtask

    task automatic issue_edge(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(posedge CLK);
        model_apply(fn, a, b);
        #1;
        chk("busy_after_issue", 32'(Busy), 32'd1);
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(posedge CLK);
        #1;
        drive(fn, a, b);
        issue_edge(fn, a, b);
    endtask

    task automatic wait_done(input int lat, input logic [5:0] hold_fn,
                             input logic [31:0] ha, input logic [31:0] hb, input bit rand_ops);
        int   cyc;
        logic exp_stall;
        cyc = 0;
        exp_stall = is_hilo(hold_fn);
        drive(hold_fn, ha, hb);
        if (hold_fn == F_MFLO) exp_q.push_back(m_lo);
        forever begin
            @(negedge CLK);
            if (!Busy) break;
            cyc++;
            chk("stall_while_busy", 32'(Stall), 32'(exp_stall));
            if (hold_fn == F_MFLO) chk("hilodata_while_busy", HiLoData, 32'd0);
            if (cyc > 100) break;
            if (rand_ops) begin
                #1;
                Rdata1 = $urandom;
                Rdata2 = $urandom;
            end
        end
        chk("busy_latency", 32'(cyc), 32'(lat));
        #1;
    endtask

    task automatic read_exp(input logic [5:0] fn, input logic [31:0] val);
        @(posedge CLK);
        #1;
        drive(fn, $urandom, $urandom);
        exp_q.push_back(val);
        @(negedge CLK);
        chk("read_stall", 32'(Stall), 32'd0);
        #1;
    endtask

    task automatic read(input logic [5:0] fn);
        read_exp(fn, (fn == F_MFHI) ? m_hi : m_lo);
    endtask

    task automatic write(input logic [5:0] fn, input logic [31:0] v);
        @(posedge CLK);
        #1;
        drive(fn, v, $urandom);
        @(posedge CLK);
        model_apply(fn, v, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (RST && !Stall && Ins[31:26] == 6'h00 &&
            (Ins[5:0] == F_MFHI || Ins[5:0] == F_MFLO)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h, expected no read", HiLoData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hilo_read", HiLoData, mon_e);
            end
        end
    end

    initial begin
        #1;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_stall", 32'(Stall), 32'd0);
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        chk("reset_hilodata", HiLoData, 32'd0);
        chk("reset_stall_mflo", 32'(Stall), 32'd0);
        drive(F_ADD, 32'd0, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // Reset in the middle of a multiply
        write(F_MTHI, 32'h1234_5678);
        write(F_MTLO, 32'h9ABC_DEF0);
        issue(F_MULT, 32'd7, 32'd6);
        drive(F_ADD, $urandom, $urandom);
        repeat (9) @(posedge CLK);
        #2;
        chk("busy_pre_reset", 32'(Busy), 32'd1);
        drive(F_MFLO, 32'd0, 32'd0);
        RST = 1'b0;
        #1;
        chk("midreset_busy", 32'(Busy), 32'd0);
        chk("midreset_stall", 32'(Stall), 32'd0);
        chk("midreset_lo", HiLoData, 32'd0);
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        chk("midreset_hi", HiLoData, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        drive(F_ADD, 32'd0, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        read_exp(F_MFLO, 32'd0);
        read_exp(F_MFHI, 32'd0);

        issue(F_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(32, F_MFLO, $urandom, $urandom, 1);
        read_exp(F_MFHI, 32'hFFFF_FFFF);
        read_exp(F_MFLO, 32'hFFFF_FFF1);

        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(32, F_ADD, $urandom, $urandom, 1);
        read_exp(F_MFHI, 32'hFFFF_FFFE);
        read_exp(F_MFLO, 32'h0000_0001);

        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(33, F_ADD, $urandom, $urandom, 1);
        read_exp(F_MFLO, 32'hFFFF_FFFD);
        read_exp(F_MFHI, 32'hFFFF_FFFF);

        issue(F_DIVU, 32'd100, 32'd7);
        wait_done(33, F_MFLO, $urandom, $urandom, 1);
        read_exp(F_MFHI, 32'd2);
        read_exp(F_MFLO, 32'd14);

        issue(F_DIV, 32'd5, 32'd0);
        wait_done(33, F_ADD, $urandom, $urandom, 1);
        read_exp(F_MFHI, 32'd5);
        read_exp(F_MFLO, 32'hFFFF_FFFF);

        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(33, F_ADD, $urandom, $urandom, 1);
        read_exp(F_MFLO, 32'h8000_0000);
        read_exp(F_MFHI, 32'd0);

        write(F_MTHI, 32'hCAFE_F00D);
        read_exp(F_MFHI, 32'hCAFE_F00D);

        // Stalled DIVU issues on the first edge after the multiply completes
        issue(F_MULTU, 32'd123456, 32'd789);
        wait_done(32, F_DIVU, 32'hDEAD_BEEF, 32'd1000, 0);
        issue_edge(F_DIVU, 32'hDEAD_BEEF, 32'd1000);
        wait_done(33, F_ADD, $urandom, $urandom, 1);
        read(F_MFLO);
        read(F_MFHI);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       r_fn = F_MULT;
                1:       r_fn = F_MULTU;
                2:       r_fn = F_DIV;
                default: r_fn = F_DIVU;
            endcase
            r_a = pick();
            r_b = pick();
            if ($urandom_range(0, 3) == 0) write(($urandom_range(0, 1) != 0) ? F_MTHI : F_MTLO, $urandom);
            issue(r_fn, r_a, r_b);
            wait_done((r_fn == F_MULT || r_fn == F_MULTU) ? 32 : 33,
                      ($urandom_range(0, 1) != 0) ? F_MFLO : F_ADD, $urandom, $urandom, 1);
            read(F_MFHI);
            read(F_MFLO);
        end

        @(posedge CLK);
        #1;
        drive(F_ADD, 32'd0, 32'd0);
        repeat (2) @(negedge CLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with the architectural HI/LO registers. It sits in the execute stage beside the ALU and serves MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Its `HiLoData` output is selected onto the `Result` bus that feeds the data-memory/write-back stage. While an operation is in flight, the unit asserts `Stall` to freeze PC update and register write for any later HI/LO instruction.

## Interface
- `MULT_FAST`, default 0: 0 = 32-cycle shift-add multiply; 1 = multiply completes at the issue edge (latency 1, no Busy). Divide is always iterative.
- `CLK`  in  1  system clock, all state on rising edge
- `RST`  in  1  reset, asynchronous, active-low (0 = reset)
- `Ins`  in  32  current instruction; `Ins[31:26]` opcode, `Ins[5:0]` funct (codes from `common_param.vh`)
- `Rdata1`  in  32  rs value (dividend / multiplicand / MTHI, MTLO source)
- `Rdata2`  in  32  rt value (divisor / multiplier)
- `HiLoData`  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- `Stall`  out  1  hold PC and suppress register write this cycle
- `Busy`  out  1  iterative operation in progress

## Operation
- Decode: the instruction is an HI/LO op only when opcode = 6'h00 and funct is one of MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. All other `Ins` values are ignored.
- `Stall` = `Busy` AND (`Ins` is any of the 8 HI/LO ops). Non-HI/LO instructions proceed while `Busy` is high.
- Issue: a MULT/MULTU/DIV/DIVU issues at a rising edge with `Busy`=0 and `RST`=1.
  - At issue the unit captures operands, operation type and signedness.
  - Count is set to 32 and `Busy` rises.
- States: IDLE, MUL, DIV, FIX. Transitions:
  - IDLE→MUL or IDLE→DIV on issue.
  - MUL→IDLE after 32 iterations.
  - DIV→FIX after 32 iterations.
  - FIX→IDLE after 1 cycle (sign correction, HI/LO write).
- Multiply:
  - Signed MULT uses operand magnitudes and negates the 64-bit product if the signs differ.
  - Result is {HI,LO} = 64-bit product.
  - Each iteration adds (multiplicand << i) when multiplier bit i is set.
- Divide: restoring unsigned divide on magnitudes.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend (signed DIV).
- Divide by zero: HI = dividend (`Rdata1` as issued), LO = 32'hFFFFFFFF, for both DIV and DIVU.
  - Runs the full latency; no early exit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 32'h80000000, HI = 0.
- MTHI/MTLO: write `Rdata1` into HI/LO at the edge when `Busy`=0. Ignored when `Busy`=1, because the instruction is stalled and re-presented.
- MFHI/MFLO: `HiLoData` = HI/LO when `Busy`=0. When `Busy`=1, `HiLoData` = 0 and `Stall`=1.
- HI/LO change only at completion of MULT/DIV or at an MTHI/MTLO edge.

## Timing
- Reset (`RST`=0, asynchronous):
  - HI = LO = 0, `Busy` = 0, count = 0, state = IDLE.
  - Therefore `Stall` = 0 and `HiLoData` = 0.
- Reset asserted mid-operation aborts the operation immediately. HI/LO clear; no partial result is written.
- MULT/MULTU, issue at edge k:
  - `Busy`=1 after edge k.
  - HI/LO written and `Busy`=0 after edge k+32.
  - `Busy` is high for 32 cycles.
- MULT with `MULT_FAST`=1: HI/LO written at edge k; `Busy` stays 0.
- DIV/DIVU, issue at edge k: HI/LO written and `Busy`=0 after edge k+33 (32 iterations + FIX).
- An MFHI presented in the cycle after `Busy` falls reads the new value; `Stall` deasserts in that same cycle.
- A stalled MULT/DIV re-issues at the first edge with `Busy`=0. Back-to-back issue leaves 0 idle cycles.
- Operands are sampled only at issue; changes on `Rdata1`/`Rdata2` while `Busy` is high have no effect.

## Test plan
- Reset mid-op:
  - Issue MULT (7 × 6), drop `RST` at cycle 10.
  - Required: `Busy`=0, HI=LO=0 immediately; after reset release, MFLO gives 0.
- MULT −3 × 5:
  - Issue, hold `Ins`=MFLO during the busy period.
  - Required: `Stall`=1 for 32 cycles; then HI = 32'hFFFFFFFF and LO = 32'hFFFFFFF1.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → HI = 32'hFFFFFFFE, LO = 32'h00000001.
- DIV −7 / 2 → LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF after 33 cycles. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV edge cases:
  - DIV 5 / 0 → HI = 5, LO = 32'hFFFFFFFF.
  - DIV 32'h80000000 / 32'hFFFFFFFF → LO = 32'h80000000, HI = 0.
- Writes and non-blocking:
  - MTHI 32'hCAFEF00D then MFHI: returns 32'hCAFEF00D with `Stall`=0.
  - A non-HI/LO ADD during `Busy`: `Stall`=0.
